lc4_div_iter: RTL and testbench

- Multi-cycle unsigned integer divider for the LC4 pipeline's DIV/MOD path; the subtract/restore counterpart to the CLA add path.
- Computes quotient and remainder one bit per cycle (restoring algorithm), behind a valid/ready handshake.
- Sits beside the ALU; the pipeline stalls while `in_ready` is low or `out_valid` is pending.

---
 rtl/lc4_div_iter.sv | 140 ++++++++++++++
 tb/tb_lc4_div_iter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lc4_div_iter.sv
//------------------------------------------------------------------------------
// Module   : lc4_div_iter
// Brief    : Restoring unsigned divider, one quotient bit per cycle, behind a
//            valid/ready handshake. Optional macro LC4_DIV_EARLY_EN enables the
//            short path for divisor==0 or dividend<divisor.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lc4_div_iter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] r_d;
    logic             r_dz;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;

    logic [WIDTH:0]   w_s;
    logic             w_ge;
    logic [WIDTH-1:0] w_r_next;
    logic [WIDTH-1:0] w_q_next;
    logic             w_last;
    logic             w_take_early;

`ifdef LC4_DIV_EARLY_EN
    logic             r_early;
    assign w_take_early = r_early;
`else
    assign w_take_early = 1'b0;
`endif

    // The running remainder stays below the divisor, so it only needs WIDTH
    // bits; the compare is done at WIDTH+1 and the difference always fits.
    assign w_s      = {r_r, r_q[WIDTH-1]};
    assign w_ge     = (w_s >= {1'b0, r_d});
    assign w_r_next = w_ge ? (w_s[WIDTH-1:0] - r_d) : w_s[WIDTH-1:0];
    assign w_q_next = {r_q[WIDTH-2:0], w_ge};
    assign w_last   = (r_cnt == c_last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_q         <= '0;
            r_r         <= '0;
            r_d         <= '0;
            r_dz        <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_quot      <= '0;
            r_rem       <= '0;
`ifdef LC4_DIV_EARLY_EN
            r_early     <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_q        <= in_dividend;
                        r_r        <= '0;
                        r_d        <= in_divisor;
                        r_cnt      <= '0;
                        r_dz       <= (in_divisor == '0);
`ifdef LC4_DIV_EARLY_EN
                        r_early    <= (in_divisor == '0) || (in_dividend < in_divisor);
`endif
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    if (w_take_early) begin
                        // Dividend is still untouched in r_q here
                        r_quot      <= '0;
                        r_rem       <= r_dz ? '0 : r_q;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_q   <= w_q_next;
                        r_r   <= w_r_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_quot      <= r_dz ? '0 : w_q_next;
                            r_rem       <= r_dz ? '0 : w_r_next;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready      = r_in_ready;
    assign out_valid     = r_out_valid;
    assign out_quotient  = r_quot;
    assign out_remainder = r_rem;

endmodule

`default_nettype wire

// File: tb/tb_lc4_div_iter.sv
//------------------------------------------------------------------------------
// Module   : tb_lc4_div_iter
// Brief    : Scoreboard bench for lc4_div_iter with an arithmetic reference.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_lc4_div_iter;

    localparam int WIDTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] in_dividend = '0;
    logic [15:0] in_divisor = '0;
    logic [15:0] out_quotient;
    logic [15:0] out_remainder;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] dvd;
        logic [15:0] dvs;
        logic [15:0] q;
        logic [15:0] r;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lc4_div_iter #(.WIDTH(16), .CNT_W(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_dividend  (in_dividend),
        .in_divisor   (in_divisor),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_quotient (out_quotient),
        .out_remainder(out_remainder)
    );

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input int acc);
        exp_t e;
        e.dvd = a;
        e.dvs = b;
        e.acc = acc;
        if (b == 16'd0) begin
            e.q = 16'd0;
            e.r = 16'd0;
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        e.lat = WIDTH;
`ifdef LC4_DIV_EARLY_EN
        if (b == 16'd0 || a < b) e.lat = 1;
`endif
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // Inputs set here are what the next rising edge sees
    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic ordy, output bit acc);
        @(negedge clk);
        in_valid    = v;
        in_dividend = a;
        in_divisor  = b;
        out_ready   = ordy;
        acc = (v === 1'b1) && (in_ready === 1'b1) && (rst_n === 1'b1);
        if (acc) begin
            chk("single_outstanding", sb.size(), 0);
            sb.push_back(model(a, b, cyc));
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold);
        bit acc;
        bit fired;
        int vcnt;
        acc = 1'b0;
        for (int n = 0; n < 20 && !acc; n++) drive(1'b1, a, b, 1'b0, acc);
        if (!acc) fail_now("accept_timeout");
        fired = 1'b0;
        vcnt  = 0;
        for (int n = 0; n < 100 && !fired; n++) begin
            @(negedge clk);
            in_valid    = (in_ready === 1'b1) ? 1'b0 : 1'($urandom % 2);
            in_dividend = 16'($urandom);
            in_divisor  = 16'($urandom);
            if (out_valid === 1'b1) begin
                vcnt++;
                chk("busy_in_ready", in_ready, 0);
            end
            out_ready = (out_valid === 1'b1) && (vcnt > hold);
            fired = out_ready;
        end
        if (!fired) fail_now("result_timeout");
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("release_in_ready", in_ready, 1);
        chk("release_out_valid", out_valid, 0);
    endtask

    initial begin : monitor
        exp_t e;
        bit   prev_v;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n !== 1'b1) begin
                prev_v = 1'b0;
                continue;
            end
            if (out_valid === 1'b1 && in_ready === 1'b1)
                chk("ready_valid_exclusive", {out_valid, in_ready}, 2'b10);
            if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    fail_now("spurious_result");
                end else begin
                    e = sb[0];
                    if (!prev_v) chk("latency", cyc, e.acc + 1 + e.lat);
                    chk("quotient", out_quotient, e.q);
                    chk("remainder", out_remainder, e.r);
                    if (e.dvs != 16'd0)
                        chk("invariant", 32'(out_quotient) * 32'(e.dvs) + 32'(out_remainder), 32'(e.dvd));
                    if (out_ready === 1'b1) void'(sb.pop_front());
                end
            end
            prev_v = (out_valid === 1'b1) && (out_ready !== 1'b1);
        end
    end

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bit          acc;
        int          got;
        int          sel;
        logic [15:0] a;
        logic [15:0] b;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_quotient", out_quotient, 0);
        chk("rst_remainder", out_remainder, 0);
        rst_n = 1'b1;

        run_op(16'h0064, 16'h0007, 0);
        run_op(16'hFFFF, 16'h0001, 0);
        run_op(16'hFFFF, 16'hFFFF, 0);
        run_op(16'h0000, 16'h1234, 0);
        run_op(16'h1234, 16'h0000, 0);
        run_op(16'h0005, 16'h0009, 0);
        run_op(16'h0064, 16'h0007, 5);

        // Reset in the middle of RUN must discard the result
        acc = 1'b0;
        for (int n = 0; n < 20 && !acc; n++) drive(1'b1, 16'h1234, 16'h0056, 1'b1, acc);
        if (!acc) fail_now("accept_timeout_rst");
        for (int n = 0; n < 7; n++) drive(1'b0, 16'h0000, 16'h0000, 1'b0, acc);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_quotient", out_quotient, 0);
        sb.delete();
        rst_n = 1'b1;
        for (int n = 0; n < 20; n++) drive(1'b0, 16'h0000, 16'h0000, 1'b0, acc);
        chk("midrst_discarded", out_valid, 0);

        // Back-to-back random traffic with in_valid held high
        got = 0;
        for (int n = 0; n < 40000 && got < 1000; n++) begin
            sel = int'($urandom % 6);
            a = 16'($urandom);
            b = 16'($urandom);
            case (sel)
                0: b = 16'd0;
                1: b = 16'($urandom % 16 + 1);
                2: a = (b == 16'd0) ? 16'd0 : 16'($urandom % b);
                default: ;
            endcase
            drive(1'b1, a, b, 1'($urandom % 2), acc);
            if (acc) got++;
        end
        chk("random_accepts", got, 1000);

        for (int n = 0; n < 100 && sb.size() != 0; n++) drive(1'b0, 16'h0000, 16'h0000, 1'b1, acc);
        chk("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
